// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Purpose  : Shared constants and typedefs for the 256 x 16-bit register file.
// Contents : RF_DATA_W / RF_ADDR_W / RF_DEPTH sizing constants,
//            rf_addr_t and rf_data_t typedefs for code that handles
//            register-file addresses and data words.
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 8;
    localparam int RF_DEPTH  = 256;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_word.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_word
// Purpose  : One storage word of the register file: a DATA_W-bit register
//            with synchronous active-high clear and a write enable.
//            Clear takes priority over the enable.
// Ports    : clk_i  - clock, rising edge
//            rst_i  - synchronous active-high clear
//            en_i   - write enable for this word
//            d_i    - data to store when en_i is high
//            q_o    - current stored value
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_word
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule : reg_file_word
`default_nettype wire

// File: rtl/reg_file256_16b.sv
`default_nettype none
// ============================================================================
// Module   : reg_file256_16b
// Purpose  : 256-entry x 16-bit single-port register file. One shared
//            address selects the entry for both the clocked write and the
//            combinational read. Synchronous reset clears every entry and
//            wins over a simultaneous write.
// Ports    : CLK       - clock, rising edge
//            reset     - synchronous active-high clear of all entries
//            address   - entry select for read and write (ADDR_W bits)
//            writeData - data stored when write is high (DATA_W bits)
//            write     - write enable, sampled on the rising edge
//            readData  - combinational contents of the addressed entry
// Options  : REGFILE_WRITE_BYPASS_EN - when defined, readData forwards
//            writeData during a write cycle and shows 0 during reset;
//            stored state is identical with or without it.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file256_16b
    import reg_file_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    // Must equal 2**ADDR_W: every address value maps to exactly one entry.
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              write,
    output logic [DATA_W-1:0] readData
);

    // Per-entry write enables from the address decoder.
    logic [DEPTH-1:0]  word_en;
    // Outputs of all storage words, indexed by entry number.
    logic [DATA_W-1:0] word_q [DEPTH];
    // Output of the 256:1 read multiplexer.
    logic [DATA_W-1:0] rd_mem;

    // ------------------------------------------------------------------
    // Address decoder and storage words. The reset is routed straight to
    // every word so it clears the whole array regardless of address, and
    // the word's own clear-over-enable priority discards a concurrent write.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign word_en[i] = write && (address == ADDR_W'(i));

        reg_file_word #(
            .DATA_W (DATA_W)
        ) u_word (
            .clk_i (CLK),
            .rst_i (reset),
            .en_i  (word_en[i]),
            .d_i   (writeData),
            .q_o   (word_q[i])
        );
    end

    // Read multiplexer: full decode, no latency.
    assign rd_mem = word_q[address];

`ifdef REGFILE_WRITE_BYPASS_EN
    // Write-first view: show what the array will hold after this edge.
    // During reset the array is about to be cleared, so show 0.
    always_comb begin
        readData = rd_mem;
        if (reset) begin
            readData = '0;
        end else if (write) begin
            readData = writeData;
        end
    end
`else
    // Read-first view: old contents stay visible until the write edge.
    assign readData = rd_mem;
`endif

endmodule : reg_file256_16b
`default_nettype wire

// File: tb/tb_reg_file256_16b.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file256_16b
// Purpose  : Self-checking bench for reg_file256_16b. Drives directed and
//            random cycles and compares readData against an array-based
//            reference model of the register file contents.
// Options  : REGFILE_WRITE_BYPASS_EN - selects the write-first read view
//            in the expected-value function, matching the DUT build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file256_16b;

    logic        CLK;
    logic        reset;
    logic [7:0]  address;
    logic [15:0] writeData;
    logic        write;
    logic [15:0] readData;

    int checks;
    int errors;

    // Reference model: plain array of entry contents.
    logic [15:0] mdl [256];

    reg_file256_16b dut (
        .CLK       (CLK),
        .reset     (reset),
        .address   (address),
        .writeData (writeData),
        .write     (write),
        .readData  (readData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // What readData should show right now given the model and the inputs.
    function automatic logic [15:0] exp_read();
`ifdef REGFILE_WRITE_BYPASS_EN
        if (reset) return 16'h0000;
        if (write) return writeData;
`endif
        return mdl[address];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: addr=%0d readData=%h expected=%h", tag, address, obs, exp);
        end
    endtask

    // Apply the model's view of what happens at a rising edge.
    task automatic model_edge();
        if (reset) begin
            for (int k = 0; k < 256; k++) mdl[k] = 16'h0000;
        end else if (write) begin
            mdl[address] = writeData;
        end
    endtask

    // One cycle: drive inputs after the falling edge, check readData
    // combinationally, then let the rising edge commit the cycle.
    task automatic cyc(input logic rst, input logic wr, input logic [7:0] a,
                       input logic [15:0] d, input string tag);
        @(negedge CLK);
        reset     = rst;
        write     = wr;
        address   = a;
        writeData = d;
        #1;
        chk(tag, readData, exp_read());
        @(posedge CLK);
        model_edge();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        write     = 1'b0;
        address   = 8'd0;
        writeData = 16'h0000;
        for (int k = 0; k < 256; k++) mdl[k] = 16'hxxxx;

        // Initial reset: contents are undefined beforehand, so no checks yet.
        @(posedge CLK);
        model_edge();
        @(posedge CLK);
        model_edge();

        // Reset state.
        cyc(1'b0, 1'b0, 8'd0,   16'h1111, "reset_addr0");
        cyc(1'b0, 1'b0, 8'd255, 16'h2222, "reset_addr255");

        // Fill all entries with address+1.
        for (int a = 0; a < 256; a++)
            cyc(1'b0, 1'b1, 8'(a), 16'(a + 1), "fill");
        for (int a = 0; a < 256; a++)
            cyc(1'b0, 1'b0, 8'(a), 16'($urandom), "fill_sweep");

        // One reset edge clears everything.
        cyc(1'b1, 1'b0, 8'd7, 16'h0000, "reset_pulse");
        for (int a = 0; a < 256; a++)
            cyc(1'b0, 1'b0, 8'(a), 16'($urandom), "reset_sweep");

        // Single write then read with a different writeData present.
        cyc(1'b0, 1'b1, 8'd69, 16'd420, "single_wr");
        cyc(1'b0, 1'b0, 8'd69, 16'd25,  "single_rd69");
        cyc(1'b0, 1'b0, 8'd68, 16'd25,  "single_rd68");
        cyc(1'b0, 1'b0, 8'd70, 16'd25,  "single_rd70");

        // Reset wins over a simultaneous write.
        cyc(1'b0, 1'b1, 8'd4, 16'h7777, "pre_prio_wr");
        cyc(1'b1, 1'b1, 8'd4, 16'hBEEF, "prio_edge");
        cyc(1'b0, 1'b0, 8'd4, 16'h0000, "prio_rd4");
        cyc(1'b0, 1'b0, 8'd69, 16'h0000, "prio_rd69");

        // Overwrite on consecutive edges, neighbours untouched.
        cyc(1'b0, 1'b1, 8'd4, 16'h1234, "ovw_wr1");
        cyc(1'b0, 1'b1, 8'd4, 16'hABCD, "ovw_wr2");
        cyc(1'b0, 1'b0, 8'd4, 16'h0000, "ovw_rd4");
        cyc(1'b0, 1'b0, 8'd3, 16'h0000, "ovw_rd3");
        cyc(1'b0, 1'b0, 8'd5, 16'h0000, "ovw_rd5");

        // Write-cycle read view at address 10 (old value vs forwarded data).
        cyc(1'b0, 1'b1, 8'd10, 16'h1357, "byp_setup");
        cyc(1'b0, 1'b1, 8'd10, 16'h5A5A, "byp_wr");
        cyc(1'b0, 1'b0, 8'd10, 16'h0000, "byp_after");

        // Held write keeps writing current data every edge.
        cyc(1'b0, 1'b1, 8'd200, 16'h0001, "hold_wr1");
        cyc(1'b0, 1'b1, 8'd200, 16'h0002, "hold_wr2");
        cyc(1'b0, 1'b1, 8'd200, 16'h0003, "hold_wr3");
        cyc(1'b0, 1'b0, 8'd200, 16'h0000, "hold_rd");

        // Random traffic with occasional reset.
        for (int n = 0; n < 1500; n++) begin
            logic        r_rst;
            logic        r_wr;
            logic [7:0]  r_a;
            logic [15:0] r_d;
            r_rst = ($urandom_range(0, 63) == 0);
            r_wr  = ($urandom_range(0, 1) == 1);
            // Concentrate addresses sometimes so reads hit written entries.
            r_a   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            r_d   = 16'($urandom);
            cyc(r_rst, r_wr, r_a, r_d, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_reg_file256_16b
`default_nettype wire
